// File: rtl/mult_job_driver.sv
// Job driver for the multiply core: loads two signed operands into data memory,
// runs the core until done or timeout, reads the product back and checks it.
module mult_job_driver #(
  parameter logic [7:0]  OPA_ADDR = 8'd1,
  parameter logic [7:0]  RES_ADDR = 8'd5,
  parameter logic [15:0] TIMEOUT  = 16'd4096
) (
  input  logic        CLK,
  input  logic        rst_n,
  input  logic        go,
  input  logic [15:0] opa,
  input  logic [15:0] opb,
  output logic        busy,
  output logic        dut_start,
  input  logic        dut_done,
  output logic        mem_we,
  output logic [7:0]  mem_addr,
  output logic [7:0]  mem_wdata,
  input  logic [7:0]  mem_rdata,
  output logic [31:0] result,
  output logic        result_valid,
  output logic        pass,
  output logic        timeout,
  output logic [15:0] cycles
);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_LAUNCH, S_RUN, S_READ, S_CHECK
  } state_t;

  state_t      state_q, state_d;
  logic [1:0]  beat_q, beat_d;
  logic [15:0] opa_q, opa_d, opb_q, opb_d;
  logic [31:0] golden_q, golden_d;
  logic [31:0] result_q, result_d;
  logic        result_valid_q, result_valid_d;
  logic        pass_q, pass_d;
  logic        timeout_q, timeout_d;
  logic [15:0] cycles_q, cycles_d;
  logic        busy_q, busy_d;
  logic        dut_start_q, dut_start_d;

  logic signed [31:0] opa_ext, opb_ext;
  logic [15:0]        cycles_inc;

  assign opa_ext    = {{16{opa[15]}}, opa};
  assign opb_ext    = {{16{opb[15]}}, opb};
  assign cycles_inc = (cycles_q == 16'hFFFF) ? cycles_q : cycles_q + 16'd1;

  always_comb begin
    state_d        = state_q;
    beat_d         = beat_q;
    opa_d          = opa_q;
    opb_d          = opb_q;
    golden_d       = golden_q;
    result_d       = result_q;
    result_valid_d = 1'b0;
    pass_d         = pass_q;
    timeout_d      = timeout_q;
    cycles_d       = cycles_q;
    busy_d         = busy_q;
    dut_start_d    = dut_start_q;
    mem_we         = 1'b0;
    mem_addr       = '0;
    mem_wdata      = '0;

    case (state_q)
      S_IDLE: begin
        if (go) begin
          opa_d     = opa;
          opb_d     = opb;
          golden_d  = opa_ext * opb_ext;
          pass_d    = 1'b0;
          timeout_d = 1'b0;
          cycles_d  = '0;
          beat_d    = '0;
          busy_d    = 1'b1;
          state_d   = S_LOAD;
        end
      end
      S_LOAD: begin
        mem_we   = 1'b1;
        mem_addr = OPA_ADDR + {6'd0, beat_q};
        case (beat_q)
          2'd0:    mem_wdata = opa_q[15:8];
          2'd1:    mem_wdata = opa_q[7:0];
          2'd2:    mem_wdata = opb_q[15:8];
          default: mem_wdata = opb_q[7:0];
        endcase
        beat_d = beat_q + 2'd1;
        if (beat_q == 2'd3) begin
          dut_start_d = 1'b0;
          state_d     = S_LAUNCH;
        end
      end
      S_LAUNCH: begin
        state_d = S_RUN;
      end
      S_RUN: begin
        // done wins over timeout; the timeout cycle itself leaves cycles at TIMEOUT
        if (dut_done) begin
          cycles_d    = cycles_inc;
          dut_start_d = 1'b1;
          beat_d      = '0;
          state_d     = S_READ;
        end else if (cycles_q >= TIMEOUT) begin
          timeout_d   = 1'b1;
          dut_start_d = 1'b1;
          beat_d      = '0;
          state_d     = S_READ;
        end else begin
          cycles_d = cycles_inc;
        end
      end
      S_READ: begin
        mem_addr = RES_ADDR + {6'd0, beat_q};
        // MSB-first shift lands byte k at result[31-8k -: 8] after four beats
        result_d = {result_q[23:0], mem_rdata};
        beat_d   = beat_q + 2'd1;
        if (beat_q == 2'd3) begin
          result_valid_d = 1'b1;
          state_d        = S_CHECK;
        end
      end
      S_CHECK: begin
        pass_d  = (result_q == golden_q) && !timeout_q;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!rst_n) begin
      state_q        <= S_IDLE;
      beat_q         <= '0;
      opa_q          <= '0;
      opb_q          <= '0;
      golden_q       <= '0;
      result_q       <= '0;
      result_valid_q <= 1'b0;
      pass_q         <= 1'b0;
      timeout_q      <= 1'b0;
      cycles_q       <= '0;
      busy_q         <= 1'b0;
      dut_start_q    <= 1'b1;
    end else begin
      state_q        <= state_d;
      beat_q         <= beat_d;
      opa_q          <= opa_d;
      opb_q          <= opb_d;
      golden_q       <= golden_d;
      result_q       <= result_d;
      result_valid_q <= result_valid_d;
      pass_q         <= pass_d;
      timeout_q      <= timeout_d;
      cycles_q       <= cycles_d;
      busy_q         <= busy_d;
      dut_start_q    <= dut_start_d;
    end
  end

  assign busy         = busy_q;
  assign dut_start    = dut_start_q;
  assign result       = result_q;
  assign result_valid = result_valid_q;
  assign pass         = pass_q;
  assign timeout      = timeout_q;
  assign cycles       = cycles_q;

endmodule

// File: tb/tb_mult_job_driver.sv
// Bench for mult_job_driver: byte memory plus a behavioural multiply core,
// directed and random jobs checked against arithmetic expectations.
module tb_mult_job_driver;

  localparam logic [15:0] TO = 16'd32;

  logic        CLK = 1'b0;
  logic        rst_n;
  logic        go;
  logic [15:0] opa, opb;
  logic        busy, dut_start, dut_done;
  logic        mem_we;
  logic [7:0]  mem_addr, mem_wdata, mem_rdata;
  logic [31:0] result;
  logic        result_valid, pass, timeout;
  logic [15:0] cycles;

  int checks   = 0;
  int failures = 0;

  logic [7:0]  mem [256];
  int          core_lat  = 1;
  int          core_mode = 2;
  logic [31:0] core_val  = '0;
  int          lo_cnt    = 0;
  logic        force_done = 1'b0;
  logic        core_done;
  logic [31:0] core_prod;

  always #5 CLK = ~CLK;

  mult_job_driver #(.OPA_ADDR(8'd1), .RES_ADDR(8'd5), .TIMEOUT(TO)) u_dut (
    .CLK(CLK), .rst_n(rst_n), .go(go), .opa(opa), .opb(opb), .busy(busy),
    .dut_start(dut_start), .dut_done(dut_done), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .result(result), .result_valid(result_valid), .pass(pass),
    .timeout(timeout), .cycles(cycles)
  );

  function automatic logic [31:0] mul16(input logic [15:0] a, input logic [15:0] b);
    int ia, ib;
    ia = int'($signed(a));
    ib = int'($signed(b));
    return 32'(ia * ib);
  endfunction

  // Behavioural core: multiplies what sits in memory 1-4 on its first run cycle,
  // then raises done in run cycle core_lat (mode 1 stores a fixed wrong value,
  // mode 2 never finishes).
  assign core_prod = (core_mode == 1) ? core_val
                   : mul16({mem[1], mem[2]}, {mem[3], mem[4]});
  assign core_done = !dut_start && core_mode != 2 && lo_cnt != 0 && lo_cnt >= core_lat;
  assign dut_done  = force_done | core_done;
  assign mem_rdata = mem[mem_addr];

  always @(posedge CLK) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
    if (dut_start) begin
      lo_cnt <= 0;
    end else begin
      if (lo_cnt == 0 && core_mode != 2) begin
        mem[5] <= core_prod[31:24];
        mem[6] <= core_prod[23:16];
        mem[7] <= core_prod[15:8];
        mem[8] <= core_prod[7:0];
      end
      lo_cnt <= lo_cnt + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset(input string nm);
    chk({nm, "_dut_start"},    32'(dut_start), 32'd1);
    chk({nm, "_busy"},         32'(busy), 32'd0);
    chk({nm, "_mem_we"},       32'(mem_we), 32'd0);
    chk({nm, "_mem_addr"},     32'(mem_addr), 32'd0);
    chk({nm, "_mem_wdata"},    32'(mem_wdata), 32'd0);
    chk({nm, "_cycles"},       32'(cycles), 32'd0);
    chk({nm, "_result_valid"}, 32'(result_valid), 32'd0);
    chk({nm, "_pass"},         32'(pass), 32'd0);
    chk({nm, "_timeout"},      32'(timeout), 32'd0);
  endtask

  // One job, called with the driver idle at #1 after a rising edge.
  task automatic run_job(input logic [15:0] a, input logic [15:0] b, input int lat,
                         input int mode, input logic [31:0] val, input bit stale,
                         input bit glitch, input int rst_at, input string nm);
    logic [31:0] g, exp_res;
    bit          exp_to, exp_pass;
    int          exp_lat, t;
    g         = mul16(a, b);
    core_lat  = lat;
    core_mode = mode;
    core_val  = val;
    exp_to    = (mode == 2);
    exp_lat   = exp_to ? int'(TO) + 10 : lat + 9;
    opa = a; opb = b; go = 1'b1; force_done = stale;
    @(posedge CLK); #1;
    go = 1'b0;
    t  = 0;
    chk({nm, "_busy_start"}, 32'(busy), 32'd1);
    while (result_valid !== 1'b1 && t < exp_lat + 4) begin
      @(posedge CLK); #1;
      t++;
      if (t == 5) force_done = 1'b0;
      if (glitch && t == 10) begin go = 1'b1; opa = ~a; opb = b ^ 16'h00FF; end
      if (glitch && t == 11) go = 1'b0;
      if (rst_at != 0 && t == rst_at) begin
        chk({nm, "_cycles_before_reset"}, 32'(cycles), 32'(rst_at - 5));
        rst_n = 1'b0;
        @(posedge CLK); #1;
        chk_reset({nm, "_rst"});
        rst_n = 1'b1;
        @(posedge CLK); #1;
        return;
      end
    end
    exp_res  = exp_to ? {mem[5], mem[6], mem[7], mem[8]} : ((mode == 1) ? val : g);
    exp_pass = !exp_to && (exp_res == g);
    chk({nm, "_valid_latency"}, 32'(t), 32'(exp_lat));
    chk({nm, "_result"},  result, exp_res);
    chk({nm, "_timeout"}, 32'(timeout), 32'(exp_to));
    chk({nm, "_cycles"},  32'(cycles), exp_to ? 32'(TO) : 32'(lat));
    chk({nm, "_mem_ops"}, {mem[1], mem[2], mem[3], mem[4]}, {a, b});
    chk({nm, "_busy_check"}, 32'(busy), 32'd1);
    @(posedge CLK); #1;
    chk({nm, "_pass"}, 32'(pass), 32'(exp_pass));
    chk({nm, "_busy_done"}, 32'(busy), 32'd0);
    chk({nm, "_valid_pulse"}, 32'(result_valid), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; go = 1'b0; opa = '0; opb = '0;
    repeat (2) @(posedge CLK);
    #1;
    chk_reset("por");
    rst_n = 1'b1;
    @(posedge CLK); #1;

    run_job(16'd3, 16'hFFFB, 20, 1, 32'hFFFFFFF1, 1'b0, 1'b0, 0, "neg");
    run_job(16'h7FFF, 16'h7FFF, 7, 0, '0, 1'b0, 1'b0, 0, "maxpos");
    run_job(16'h8000, 16'h8000, 5, 1, 32'h3FFF0000, 1'b0, 1'b0, 0, "badcore");
    run_job(16'h1234, 16'hFEDC, 1, 0, '0, 1'b0, 1'b0, 0, "lat1");
    run_job(16'h0101, 16'h0202, int'(TO), 0, '0, 1'b0, 1'b0, 0, "lat_to");
    run_job(16'h0042, 16'h0013, 1, 2, '0, 1'b1, 1'b0, 0, "timeout");
    run_job(16'h00AA, 16'h0055, 20, 0, '0, 1'b0, 1'b0, 8, "reset");
    run_job(16'hC001, 16'h0777, 12, 0, '0, 1'b0, 1'b0, 0, "after_rst");
    run_job(16'h0F0F, 16'hF0F0, 20, 0, '0, 1'b0, 1'b1, 0, "glitch");
    for (int i = 0; i < 6; i++) begin
      run_job(16'($urandom), 16'($urandom), int'($urandom_range(1, 31)), 0, '0,
              1'($urandom_range(0, 1)), 1'b0, 0, "rnd");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
